// File: rtl/led_sample_scheduler_if.sv
// led_sample_scheduler_if: analog front-end bus (LED enables, drive, DC comp, PGA, ADC sample)
interface led_sample_scheduler_if;
  logic       LED_RED;
  logic       LED_IR;
  logic [3:0] LED_DRIVE;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] ADC;
  modport master (output LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain, input ADC);
  modport slave (input LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain, output ADC);
endinterface

// File: rtl/led_sample_scheduler.sv
// led_sample_scheduler: sequences RED/dark/IR/dark acquisition frames and averages ADC samples per channel
module led_sample_scheduler #(
  parameter int SETTLE_CYCLES = 8,
  parameter int AVG_LOG2      = 2,
  parameter int DARK_CYCLES   = 4
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [6:0]                    RED_DC_Comp,
  input  logic [6:0]                    IR_DC_Comp,
  input  logic [3:0]                    RED_PGA,
  input  logic [3:0]                    IR_PGA,
  input  logic [3:0]                    LED_DRIVE_cfg,
  led_sample_scheduler_if.master        afe,
  output logic [7:0]                    RED_ADC_Value,
  output logic [7:0]                    IR_ADC_Value,
  output logic                          sample_valid,
  output logic                          busy
);
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ACQ_LAST = 8'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] DRK_LAST = 8'(DARK_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, RED_SETTLE, RED_ACQ, DARK1, IR_SETTLE, IR_ACQ, DARK2} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [7:0] avg;
  logic last, acq, new_frame, red_on, ir_on;
  logic led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [6:0] dc_q, dc_d, s_rdc_q, s_rdc_d, s_idc_q, s_idc_d;
  logic [3:0] pga_q, pga_d, s_rpga_q, s_rpga_d, s_ipga_q, s_ipga_d, s_drv_q, s_drv_d;
  logic [7:0] red_val_q, red_val_d, ir_val_q, ir_val_d;
  logic sv_q, sv_d;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    last = cnt_q == ((state_q == RED_SETTLE || state_q == IR_SETTLE) ? SET_LAST :
                     (state_q == RED_ACQ || state_q == IR_ACQ) ? ACQ_LAST : DRK_LAST);
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else case (state_q)
      IDLE:       state_d = RED_SETTLE;
      RED_SETTLE: if (last) state_d = RED_ACQ;
      RED_ACQ:    if (last) state_d = DARK1;
      DARK1:      if (last) state_d = IR_SETTLE;
      IR_SETTLE:  if (last) state_d = IR_ACQ;
      IR_ACQ:     if (last) state_d = DARK2;
      DARK2:      if (last) state_d = RED_SETTLE;
      default:    state_d = IDLE;
    endcase
  end
  // Outputs are computed from the next state so the registered controls line up with the state they belong to
  always_comb begin
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 8'd1;
    acq = state_q == RED_ACQ || state_q == IR_ACQ;
    acc_sum = acc_q + AW'(afe.ADC);
    acc_d = (acq && state_d == state_q) ? acc_sum : '0;
    avg = 8'(acc_sum >> AVG_LOG2);
    new_frame = state_d == RED_SETTLE && state_q != RED_SETTLE;
    s_rdc_d = new_frame ? RED_DC_Comp : s_rdc_q;
    s_idc_d = new_frame ? IR_DC_Comp : s_idc_q;
    s_rpga_d = new_frame ? RED_PGA : s_rpga_q;
    s_ipga_d = new_frame ? IR_PGA : s_ipga_q;
    s_drv_d = new_frame ? LED_DRIVE_cfg : s_drv_q;
    red_on = state_d == RED_SETTLE || state_d == RED_ACQ;
    ir_on = state_d == IR_SETTLE || state_d == IR_ACQ;
    led_red_d = red_on;
    led_ir_d = ir_on;
    dc_d = red_on ? s_rdc_d : ir_on ? s_idc_d : dc_q;
    pga_d = red_on ? s_rpga_d : ir_on ? s_ipga_d : pga_q;
    red_val_d = (state_q == RED_ACQ && state_d == DARK1) ? avg : red_val_q;
    ir_val_d = (state_q == IR_ACQ && state_d == DARK2) ? avg : ir_val_q;
    sv_d = state_q == IR_ACQ && state_d == DARK2;
  end
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      led_red_q <= 1'b0;
      led_ir_q <= 1'b0;
      dc_q <= 7'd64;
      pga_q <= '0;
      s_rdc_q <= '0;
      s_idc_q <= '0;
      s_rpga_q <= '0;
      s_ipga_q <= '0;
      s_drv_q <= '0;
      red_val_q <= '0;
      ir_val_q <= '0;
      sv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      led_red_q <= led_red_d;
      led_ir_q <= led_ir_d;
      dc_q <= dc_d;
      pga_q <= pga_d;
      s_rdc_q <= s_rdc_d;
      s_idc_q <= s_idc_d;
      s_rpga_q <= s_rpga_d;
      s_ipga_q <= s_ipga_d;
      s_drv_q <= s_drv_d;
      red_val_q <= red_val_d;
      ir_val_q <= ir_val_d;
      sv_q <= sv_d;
    end
  end
  assign afe.LED_RED = led_red_q;
  assign afe.LED_IR = led_ir_q;
  assign afe.LED_DRIVE = s_drv_q;
  assign afe.DC_Comp = dc_q;
  assign afe.PGA_Gain = pga_q;
  assign RED_ADC_Value = red_val_q;
  assign IR_ADC_Value = ir_val_q;
  assign sample_valid = sv_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_led_sample_scheduler.sv
// tb_led_sample_scheduler: random and directed frames checked against a frame-position reference model
module tb_led_sample_scheduler;
  localparam int S = 8, N = 4, D = 4, FL = 2 * (S + N + D);
  localparam int RA0 = S + 1, RA1 = S + N, IS0 = S + N + D + 1, IA0 = 2 * S + N + D + 1, IA1 = 2 * (S + N) + D;
  logic CLK = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [6:0] red_dc = '0, ir_dc = '0;
  logic [3:0] red_pga = '0, ir_pga = '0, drv_cfg = '0;
  logic [7:0] red_val, ir_val;
  logic sv, busy;
  int n_checks = 0, n_err = 0, pos, cyc = 0, last_sv;
  int m_rdc, m_idc, m_rpga, m_ipga, m_drv, m_dc, m_pga, m_red, m_ir, m_sv, rsum, isum, held;
  int seq[4] = '{10, 20, 30, 41};
  led_sample_scheduler_if afe();
  led_sample_scheduler dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable),
    .RED_DC_Comp(red_dc), .IR_DC_Comp(ir_dc), .RED_PGA(red_pga), .IR_PGA(ir_pga),
    .LED_DRIVE_cfg(drv_cfg), .afe(afe.master),
    .RED_ADC_Value(red_val), .IR_ADC_Value(ir_val), .sample_valid(sv), .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, frame pos %0d)", tag, got, exp, cyc, pos);
    end
  endtask
  function automatic bit red_on(input int p);
    return p >= 1 && p <= S + N;
  endfunction
  function automatic bit ir_on(input int p);
    return p >= IS0 && p <= IA1;
  endfunction
  task automatic model_reset;
    pos = 0; m_rdc = 0; m_idc = 0; m_rpga = 0; m_ipga = 0; m_drv = 0;
    m_dc = 64; m_pga = 0; m_red = 0; m_ir = 0; m_sv = 0; rsum = 0; isum = 0;
  endtask
  task automatic check_outs;
    chk("led_red", int'(afe.LED_RED), int'(red_on(pos)));
    chk("led_ir", int'(afe.LED_IR), int'(ir_on(pos)));
    chk("led_excl", int'(afe.LED_RED & afe.LED_IR), 0);
    chk("led_drive", int'(afe.LED_DRIVE), m_drv);
    chk("dc_comp", int'(afe.DC_Comp), m_dc);
    chk("pga_gain", int'(afe.PGA_Gain), m_pga);
    chk("red_value", int'(red_val), m_red);
    chk("ir_value", int'(ir_val), m_ir);
    chk("sample_valid", int'(sv), m_sv);
    chk("busy", int'(busy), int'(pos != 0));
  endtask
  task automatic step(input logic en, input int adc);
    enable = en;
    afe.ADC = 8'(adc);
    @(posedge CLK);
    cyc++;
    m_sv = 0;
    if (!en) pos = 0;
    else begin
      if (pos >= RA0 && pos <= RA1) rsum += adc;
      if (pos == RA1) m_red = rsum / N;
      if (pos >= IA0 && pos <= IA1) isum += adc;
      if (pos == IA1) begin m_ir = isum / N; m_sv = 1; end
      if (pos == 0 || pos == FL) begin
        pos = 1; rsum = 0; isum = 0;
        m_rdc = red_dc; m_idc = ir_dc; m_rpga = red_pga; m_ipga = ir_pga; m_drv = drv_cfg;
      end else pos++;
    end
    if (red_on(pos)) begin m_dc = m_rdc; m_pga = m_rpga; end
    else if (ir_on(pos)) begin m_dc = m_idc; m_pga = m_ipga; end
    #1;
    check_outs;
  endtask
  initial begin
    model_reset;
    afe.ADC = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_outs;
    rst_n = 1'b1;
    red_dc = 7'd40; red_pga = 4'd5; ir_dc = 7'd20; ir_pga = 4'd3; drv_cfg = 4'd7;
    repeat (FL) step(1'b1, 100);
    chk("const_red", int'(red_val), 100);
    chk("const_ir", int'(ir_val), 100);
    for (int k = 0; k < FL; k++) step(1'b1, (pos >= IA0 && pos <= IA1) ? 50 : 200);
    chk("split_red", int'(red_val), 200);
    chk("split_ir", int'(ir_val), 50);
    for (int k = 0; k < FL; k++) step(1'b1, (pos >= RA0 && pos <= RA1) ? seq[pos - RA0] : 50);
    chk("avg_trunc", int'(red_val), 25);
    for (int k = 0; k < FL; k++) begin
      if (pos == IS0 + 1) red_pga = 4'd9;
      step(1'b1, 77);
    end
    step(1'b1, 77);
    chk("pga_next", int'(afe.PGA_Gain), 9);
    for (int g = 0; g < FL && pos != RA0 + 1; g++) step(1'b1, 33);
    step(1'b0, 33);
    chk("drop_busy", int'(busy), 0);
    chk("drop_red_held", int'(red_val), 77);
    repeat (3) step(1'b0, 12);
    for (int g = 0; g < 2 * FL && pos != IA0 + 1; g++) step(1'b1, $urandom_range(0, 255));
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    model_reset;
    check_outs;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    red_dc = 7'd11; ir_dc = 7'd99; red_pga = 4'd2; ir_pga = 4'd14; drv_cfg = 4'd12;
    step(1'b1, 0);
    chk("clean_start_dc", int'(afe.DC_Comp), 11);
    last_sv = -1;
    for (int k = 0; k < 100 * FL; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        red_dc = 7'($urandom); ir_dc = 7'($urandom);
        red_pga = 4'($urandom); ir_pga = 4'($urandom); drv_cfg = 4'($urandom);
      end
      step(1'b1, $urandom_range(0, 255));
      if (sv) begin
        if (last_sv >= 0) chk("sv_period", cyc - last_sv, FL);
        last_sv = cyc;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
